// File: rtl/radar_scan_sequencer.sv
// radar_scan_sequencer: ping-pong servo sweep; at each angle it waits a
// settle time, triggers a range measurement and hands out one
// (angle, distance) sample per angle over a valid/ready handshake.
// Optional feature macro: RADAR_SCAN_AVG_EN. When defined, it takes two
// measurements per angle and averages them.
module radar_scan_sequencer #(
  parameter int unsigned ANGLE_MIN     = 0,
  parameter int unsigned ANGLE_MAX     = 180,
  parameter int unsigned ANGLE_STEP    = 2,
  parameter int unsigned SETTLE_CYCLES = 1000000,
  parameter int unsigned MEAS_TIMEOUT  = 2000000,
  parameter int unsigned DIST_W        = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [7:0]        angle_out,
  output logic              meas_start,
  input  logic              meas_done,
  input  logic [DIST_W-1:0] meas_dist,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [7:0]        sample_angle,
  output logic [DIST_W-1:0] sample_dist,
  output logic              sample_timeout,
  output logic              sweep_dir,
  output logic              busy
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > MEAS_TIMEOUT) ? SETTLE_CYCLES : MEAS_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SETTLE    = 3'd1;
  localparam logic [2:0] TRIG      = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] EMIT      = 3'd4;
  localparam logic [2:0] STEP      = 3'd5;

  localparam logic [8:0] A_MIN  = 9'(ANGLE_MIN);
  localparam logic [8:0] A_MAX  = 9'(ANGLE_MAX);
  localparam logic [8:0] A_STEP = 9'(ANGLE_STEP);

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [7:0]        angle_nxt;
  logic              dir_nxt;
  logic              start_nxt;
  logic              valid_nxt;
  logic [7:0]        s_angle_nxt;
  logic [DIST_W-1:0] s_dist_nxt;
  logic              s_to_nxt;
  logic              busy_nxt;

  logic              meas_end_c;
  logic              res_to_c;
  logic [DIST_W-1:0] res_dist_c;
  logic [8:0]        a9_c;
  logic [8:0]        up9_c;

`ifdef RADAR_SCAN_AVG_EN
  logic              second, second_nxt;
  logic [DIST_W-1:0] d0, d0_nxt;
  logic              to0, to0_nxt;
  logic [DIST_W:0]   sum_c;
`endif

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      angle_out      <= 8'(ANGLE_MIN);
      sweep_dir      <= 1'b1;
      meas_start     <= 1'b0;
      sample_valid   <= 1'b0;
      sample_angle   <= '0;
      sample_dist    <= '0;
      sample_timeout <= 1'b0;
      busy           <= 1'b0;
`ifdef RADAR_SCAN_AVG_EN
      second         <= 1'b0;
      d0             <= '0;
      to0            <= 1'b0;
`endif
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      angle_out      <= angle_nxt;
      sweep_dir      <= dir_nxt;
      meas_start     <= start_nxt;
      sample_valid   <= valid_nxt;
      sample_angle   <= s_angle_nxt;
      sample_dist    <= s_dist_nxt;
      sample_timeout <= s_to_nxt;
      busy           <= busy_nxt;
`ifdef RADAR_SCAN_AVG_EN
      second         <= second_nxt;
      d0             <= d0_nxt;
      to0            <= to0_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    angle_nxt   = angle_out;
    dir_nxt     = sweep_dir;
    start_nxt   = 1'b0;
    valid_nxt   = 1'b0;
    s_angle_nxt = sample_angle;
    s_dist_nxt  = sample_dist;
    s_to_nxt    = sample_timeout;
`ifdef RADAR_SCAN_AVG_EN
    second_nxt  = second;
    d0_nxt      = d0;
    to0_nxt     = to0;
    sum_c       = '0;
`endif

    // meas_done wins over an expiring timeout in the same cycle
    meas_end_c = meas_done || (cnt == CNT_W'(MEAS_TIMEOUT));
    res_to_c   = !meas_done;
    res_dist_c = meas_done ? meas_dist : '1;

    // 9-bit angle arithmetic so the endpoints never wrap
    a9_c  = {1'b0, angle_out};
    up9_c = a9_c + A_STEP;

    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nxt = TRIG;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      TRIG: begin
        start_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (meas_end_c) begin
`ifdef RADAR_SCAN_AVG_EN
          if (!second) begin
            second_nxt = 1'b1;
            d0_nxt     = res_dist_c;
            to0_nxt    = res_to_c;
            state_nxt  = TRIG;
          end else begin
            second_nxt  = 1'b0;
            s_angle_nxt = angle_out;
            sum_c       = {1'b0, d0} + {1'b0, res_dist_c};
            if (to0 || res_to_c) begin
              s_dist_nxt = '1;
              s_to_nxt   = 1'b1;
            end else begin
              s_dist_nxt = DIST_W'(sum_c >> 1);
              s_to_nxt   = 1'b0;
            end
            state_nxt = EMIT;
          end
`else
          s_angle_nxt = angle_out;
          s_dist_nxt  = res_dist_c;
          s_to_nxt    = res_to_c;
          state_nxt   = EMIT;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      EMIT: begin
        if (sample_valid && sample_ready) begin
          state_nxt = enable ? STEP : IDLE;
        end else begin
          valid_nxt = 1'b1;
        end
      end
      STEP: begin
        state_nxt = SETTLE;
        cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        if (sweep_dir) begin
          if (up9_c > A_MAX) begin
            if (a9_c != A_MAX) begin
              angle_nxt = 8'(A_MAX);
            end else begin
              dir_nxt   = 1'b0;
              angle_nxt = (a9_c >= A_MIN + A_STEP) ? 8'(a9_c - A_STEP) : 8'(A_MIN);
            end
          end else begin
            angle_nxt = 8'(up9_c);
          end
        end else begin
          if (a9_c < A_MIN + A_STEP) begin
            if (a9_c != A_MIN) begin
              angle_nxt = 8'(A_MIN);
            end else begin
              dir_nxt   = 1'b1;
              angle_nxt = (up9_c > A_MAX) ? 8'(A_MAX) : 8'(up9_c);
            end
          end else begin
            angle_nxt = 8'(a9_c - A_STEP);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_radar_scan_sequencer.sv
// Self-checking bench for radar_scan_sequencer with a telemeter responder
// and a behavioural sweep/sample model. Define RADAR_SCAN_AVG_EN for both
// bench and RTL to exercise the averaging build.
module tb_radar_scan_sequencer;

  localparam int unsigned A_MIN  = 0;
  localparam int unsigned A_MAX  = 6;
  localparam int unsigned A_STEP = 2;
  localparam int unsigned SETTLE = 10;
  localparam int unsigned TMO    = 50;
  localparam int unsigned DW     = 10;
`ifdef RADAR_SCAN_AVG_EN
  localparam int NM = 2;
`else
  localparam int NM = 1;
`endif
  localparam int START_LAT = 1 + SETTLE + 1;
  localparam int TMO_LAT   = START_LAT + NM * (TMO + 2);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    angle_out;
  logic          meas_start;
  logic          meas_done = 1'b0;
  logic [DW-1:0] meas_dist = '0;
  logic          sample_valid;
  logic          sample_ready = 1'b1;
  logic [7:0]    sample_angle;
  logic [DW-1:0] sample_dist;
  logic          sample_timeout;
  logic          sweep_dir;
  logic          busy;

  int checks = 0;
  int failures = 0;

  // telemeter responder controls; -1 = never answer, -2 = random
  int default_dist = 100;
  int default_delay = 5;
  int plan_arr [0:7];
  int plan_len = 0;
  int plan_rd = 0;
  int sent_q [0:255];
  int wr_idx = 0;
  int rd_idx = 0;
  int pend = 0;
  int pend_dist = 0;
  int nd = 0;

  int m_ang = 0;
  int m_dir = 1;

  radar_scan_sequencer #(
    .ANGLE_MIN(A_MIN), .ANGLE_MAX(A_MAX), .ANGLE_STEP(A_STEP),
    .SETTLE_CYCLES(SETTLE), .MEAS_TIMEOUT(TMO), .DIST_W(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .angle_out(angle_out),
    .meas_start(meas_start), .meas_done(meas_done), .meas_dist(meas_dist),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_angle(sample_angle), .sample_dist(sample_dist),
    .sample_timeout(sample_timeout), .sweep_dir(sweep_dir), .busy(busy)
  );

  always #5 clk = ~clk;

  // Telemeter model: answers each meas_start after a delay, logs what it sent
  always @(negedge clk) begin
    if (!reset_n) begin
      meas_done = 1'b0;
      pend = 0;
      wr_idx = 0;
      plan_rd = 0;
    end else begin
      meas_done = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          meas_done = 1'b1;
          meas_dist = DW'(pend_dist);
        end
      end
      if (meas_start) begin
        if (plan_rd < plan_len) begin
          nd = plan_arr[plan_rd];
          plan_rd = plan_rd + 1;
        end else if (default_dist == -2) begin
          nd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 1023));
        end else begin
          nd = default_dist;
        end
        sent_q[wr_idx & 255] = nd;
        wr_idx = wr_idx + 1;
        if (nd >= 0) begin
          pend = (default_delay < 0) ? int'($urandom_range(1, 40)) : default_delay;
          pend_dist = nd;
        end
      end
    end
  end

  // Sweep model: next angle from the ping-pong rule
  task automatic model_step();
    int cand;
    cand = (m_dir == 1) ? m_ang + int'(A_STEP) : m_ang - int'(A_STEP);
    if (m_dir == 1 && cand > int'(A_MAX)) begin
      if (m_ang != int'(A_MAX)) m_ang = A_MAX;
      else begin
        m_dir = 0;
        m_ang = (m_ang - int'(A_STEP) < int'(A_MIN)) ? int'(A_MIN) : m_ang - int'(A_STEP);
      end
    end else if (m_dir == 0 && cand < int'(A_MIN)) begin
      if (m_ang != int'(A_MIN)) m_ang = A_MIN;
      else begin
        m_dir = 1;
        m_ang = (m_ang + int'(A_STEP) > int'(A_MAX)) ? int'(A_MAX) : m_ang + int'(A_STEP);
      end
    end else begin
      m_ang = cand;
    end
  endtask

  // Expected sample distance from the measurements the responder produced
  task automatic model_expect(output int ed, output bit et);
    int s;
    s = 0;
    et = 1'b0;
    for (int i = 0; i < NM; i++) begin
      int v;
      v = sent_q[rd_idx & 255];
      rd_idx = rd_idx + 1;
      if (v < 0) et = 1'b1;
      else s = s + v;
    end
    ed = et ? 1023 : s / NM;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    sample_ready = 1'b1;
    plan_len = 0;
    rd_idx = 0;
    default_dist = 100;
    default_delay = 5;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_start(output int n);
    n = -1;
    for (int i = 1; i <= 300 && n < 0; i++) begin
      @(negedge clk);
      if (meas_start) n = i;
    end
  endtask

  task automatic collect(output bit got, output logic [7:0] a, output logic [DW-1:0] d,
                         output logic t, output logic dir);
    got = 1'b0; a = '0; d = '0; t = 1'b0; dir = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (sample_valid) got = 1'b1;
    end
    if (got) begin
      a = sample_angle; d = sample_dist; t = sample_timeout; dir = sweep_dir;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (angle_out !== 8'd0) begin failures++; $display("FAIL reset_angle got=%0d exp=0", angle_out); end
    checks++; if (sweep_dir !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b exp=1", sweep_dir); end
    checks++; if (meas_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", meas_start); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    checks++; if (sample_angle !== 8'd0) begin failures++; $display("FAIL reset_sangle got=%0d exp=0", sample_angle); end
    checks++; if (sample_dist !== 10'd0) begin failures++; $display("FAIL reset_sdist got=%0d exp=0", sample_dist); end
    checks++; if (sample_timeout !== 1'b0) begin failures++; $display("FAIL reset_sto got=%b exp=0", sample_timeout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_sweep();
    int n, ed;
    bit et, got;
    logic [7:0] ga; logic [DW-1:0] gd; logic gt, gdir;
    do_reset();
    m_ang = A_MIN; m_dir = 1;
    enable = 1'b1;
    wait_start(n);
    checks++; if (n != START_LAT) begin failures++; $display("FAIL sweep_latency got=%0d exp=%0d", n, START_LAT); end
    for (int k = 0; k < 8; k++) begin
      collect(got, ga, gd, gt, gdir);
      checks++; if (!got) begin failures++; $display("FAIL sweep_nosample[%0d] got=none exp=sample", k); end
      model_expect(ed, et);
      checks++;
      if (ga !== 8'(m_ang) || gd !== DW'(ed) || gt !== et || gdir !== 1'(m_dir)) begin
        failures++;
        $display("FAIL sweep_sample[%0d] got=(%0d,%0d,to%0b,dir%0b) exp=(%0d,%0d,to%0b,dir%0d)",
                 k, ga, gd, gt, gdir, m_ang, ed, et, m_dir);
      end
      @(negedge clk);
      model_step();
    end
  endtask

  task automatic test_timeout();
    int first_start, valid_at, n;
    do_reset();
    default_dist = -1;
    enable = 1'b1;
    first_start = -1; valid_at = -1;
    for (int i = 1; i <= 400 && valid_at < 0; i++) begin
      @(negedge clk);
      if (meas_start && first_start < 0) first_start = i;
      if (sample_valid) valid_at = i;
    end
    checks++; if (first_start != START_LAT) begin failures++; $display("FAIL to_start got=%0d exp=%0d", first_start, START_LAT); end
    checks++; if (valid_at != TMO_LAT) begin failures++; $display("FAIL to_valid_cycle got=%0d exp=%0d", valid_at, TMO_LAT); end
    checks++;
    if (sample_dist !== 10'd1023 || sample_timeout !== 1'b1 || sample_angle !== 8'd0) begin
      failures++;
      $display("FAIL to_sample got=(%0d,%0d,to%0b) exp=(0,1023,to1)", sample_angle, sample_dist, sample_timeout);
    end
    wait_start(n);
    checks++; if (n < 0 || angle_out !== 8'd2) begin failures++; $display("FAIL to_next_angle got=%0d exp=2", angle_out); end
  endtask

  task automatic test_backpressure();
    bit got;
    int bad;
    logic [7:0] ga, ao; logic [DW-1:0] gd; logic gt, gdir;
    do_reset();
    sample_ready = 1'b0;
    enable = 1'b1;
    collect(got, ga, gd, gt, gdir);
    ao = angle_out;
    checks++; if (!got || ga !== 8'd0 || gd !== 10'd100) begin failures++; $display("FAIL bp_sample got=(%0d,%0d) exp=(0,100)", ga, gd); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample_valid !== 1'b1 || sample_angle !== ga || sample_dist !== gd ||
          sample_timeout !== gt || angle_out !== ao || meas_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d_unstable_cycles exp=0", bad); end
    sample_ready = 1'b1;
    @(negedge clk);
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", sample_valid); end
  endtask

  task automatic test_disable_mid();
    int n, ed, starts;
    bit et, got;
    logic [7:0] ga; logic [DW-1:0] gd; logic gt, gdir;
    do_reset();
    default_dist = 37;
    default_delay = 20;
    enable = 1'b1;
    wait_start(n);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    collect(got, ga, gd, gt, gdir);
    model_expect(ed, et);
    checks++;
    if (!got || ga !== 8'd0 || gd !== DW'(ed) || gt !== et) begin
      failures++;
      $display("FAIL dis_sample got=(%0d,%0d,to%0b) exp=(0,%0d,to%0b)", ga, gd, gt, ed, et);
    end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dis_busy got=%b exp=0", busy); end
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (meas_start) starts++;
    end
    checks++; if (starts != 0) begin failures++; $display("FAIL dis_idle_starts got=%0d exp=0", starts); end
    enable = 1'b1;
    wait_start(n);
    checks++;
    if (n != START_LAT || angle_out !== 8'd0) begin
      failures++;
      $display("FAIL dis_resume got=(lat%0d,ang%0d) exp=(lat%0d,ang0)", n, angle_out, START_LAT);
    end
  endtask

  task automatic test_reset_mid();
    int n, starts;
    bit got;
    logic [7:0] ga; logic [DW-1:0] gd; logic gt, gdir;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      collect(got, ga, gd, gt, gdir);
      @(negedge clk);
    end
    for (int i = 0; i < 50 && angle_out != 8'd4; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (angle_out !== 8'd4 || busy !== 1'b1) begin failures++; $display("FAIL rst_pre got=(ang%0d,busy%b) exp=(ang4,busy1)", angle_out, busy); end
    #2;
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if (angle_out !== 8'd0 || sweep_dir !== 1'b1 || sample_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got=(ang%0d,dir%b,v%b,busy%b) exp=(ang0,dir1,v0,busy0)", angle_out, sweep_dir, sample_valid, busy);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_idx = 0;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (meas_start) starts++;
    end
    checks++; if (starts != 0) begin failures++; $display("FAIL rst_no_start got=%0d exp=0", starts); end
    enable = 1'b1;
    wait_start(n);
    checks++;
    if (n != START_LAT || angle_out !== 8'd0) begin
      failures++;
      $display("FAIL rst_restart got=(lat%0d,ang%0d) exp=(lat%0d,ang0)", n, angle_out, START_LAT);
    end
  endtask

  task automatic test_random();
    int ed, stall, bad;
    bit et, got;
    logic [7:0] ga; logic [DW-1:0] gd; logic gt, gdir;
    do_reset();
    default_dist = -2;
    default_delay = -1;
    m_ang = A_MIN; m_dir = 1;
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      stall = int'($urandom_range(0, 3));
      sample_ready = (stall == 0);
      collect(got, ga, gd, gt, gdir);
      model_expect(ed, et);
      checks++;
      if (!got || ga !== 8'(m_ang) || gd !== DW'(ed) || gt !== et || gdir !== 1'(m_dir)) begin
        failures++;
        $display("FAIL rand_sample[%0d] got=(%0d,%0d,to%0b,dir%0b) exp=(%0d,%0d,to%0b,dir%0d)",
                 k, ga, gd, gt, gdir, m_ang, ed, et, m_dir);
      end
      bad = 0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (sample_valid !== 1'b1 || sample_dist !== gd || sample_angle !== ga) bad++;
      end
      sample_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bad != 0 || sample_valid !== 1'b0) begin
        failures++;
        $display("FAIL rand_handshake[%0d] got=(unstable%0d,v%b) exp=(unstable0,v0)", k, bad, sample_valid);
      end
      model_step();
    end
  endtask

`ifdef RADAR_SCAN_AVG_EN
  task automatic test_avg();
    bit got;
    logic [7:0] ga; logic [DW-1:0] gd; logic gt, gdir;
    do_reset();
    plan_arr[0] = 100; plan_arr[1] = 103; plan_arr[2] = 100; plan_arr[3] = -1;
    plan_len = 4;
    enable = 1'b1;
    collect(got, ga, gd, gt, gdir);
    checks++; if (!got || gd !== 10'd101 || gt !== 1'b0) begin failures++; $display("FAIL avg_mean got=(%0d,to%0b) exp=(101,to0)", gd, gt); end
    @(negedge clk);
    collect(got, ga, gd, gt, gdir);
    checks++;
    if (!got || ga !== 8'd2 || gd !== 10'd1023 || gt !== 1'b1) begin
      failures++;
      $display("FAIL avg_timeout got=(%0d,%0d,to%0b) exp=(2,1023,to1)", ga, gd, gt);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_timeout();
    test_backpressure();
    test_disable_mid();
    test_reset_mid();
    test_random();
`ifdef RADAR_SCAN_AVG_EN
    test_avg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
